// File: rtl/fft_stage_sequencer.sv
// Stage/address sequencer for an in-place radix-2 FFT: issues butterfly addresses, operand mux control and ping-pong bank select.
// Optional inter-stage idle gap is compiled in with macro FFT_SEQ_DRAIN_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; all outputs 0
// S_RUN   | one butterfly per cycle, oaddr sweeps 0..2^(FFT_N-1)-1
// S_DRAIN | idle gap of DRAIN_CYCLES between stages (FFT_SEQ_DRAIN_EN only)
// S_FIN   | one-cycle done pulse, then back to S_IDLE
module fft_stage_sequencer #(
    parameter int FFT_N        = 10,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             oact,
    output logic [1:0]       octrl,
    output logic [FFT_N-2:0] oaddr,
    output logic [3:0]       stage,
    output logic             bank
);

    localparam int             AW         = FFT_N - 1;
    localparam logic [AW-1:0]  ADDR_MAX   = '1;
    localparam logic [3:0]     STAGE_LAST = 4'(FFT_N - 1);

    if (FFT_N < 2 || FFT_N > 12 || DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255) begin : g_bad_param
        $error("fft_stage_sequencer: FFT_N must be 2..12 and DRAIN_CYCLES 1..255");
    end

`ifdef FFT_SEQ_DRAIN_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
    logic [7:0] drain_cnt_q, drain_cnt_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
`endif

    state_t        state_q, state_d;
    logic [3:0]    stage_q, stage_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          bank_q, bank_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          oact_q, oact_d;
    logic [1:0]    octrl_q, octrl_d;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        addr_d  = addr_q;
        bank_d  = bank_q;
`ifdef FFT_SEQ_DRAIN_EN
        drain_cnt_d = drain_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                stage_d = '0;
                bank_d  = 1'b0;
                addr_d  = '0;
                if (start && !abort) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                addr_d = addr_q + 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                    stage_d = '0;
                    bank_d  = 1'b0;
                end else if (addr_q == ADDR_MAX) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        stage_d = stage_q + 4'd1;
                        bank_d  = ~bank_q;
`ifdef FFT_SEQ_DRAIN_EN
                        state_d     = S_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
`endif
                    end
                end
            end
`ifdef FFT_SEQ_DRAIN_EN
            // Stage and bank were already advanced on entry; only the timer runs here.
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    stage_d = '0;
                    bank_d  = 1'b0;
                end else if (drain_cnt_q == 8'd0) begin
                    state_d = S_RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q - 8'd1;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
                stage_d = '0;
                bank_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                stage_d = '0;
                bank_d  = 1'b0;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        if (state_d != S_RUN) begin
            addr_d = '0;
        end
        oact_d = (state_d == S_RUN);
        done_d = (state_d == S_FIN);
`ifdef FFT_SEQ_DRAIN_EN
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
`else
        busy_d = (state_d == S_RUN);
`endif
        if (state_d != S_RUN) begin
            octrl_d = 2'b00;
        end else if (stage_d == 4'd0) begin
            octrl_d = 2'b10;
        end else begin
            octrl_d = addr_d[0] ? 2'b11 : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            addr_q  <= '0;
            bank_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oact_q  <= 1'b0;
            octrl_q <= 2'b00;
`ifdef FFT_SEQ_DRAIN_EN
            drain_cnt_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            oact_q  <= oact_d;
            octrl_q <= octrl_d;
`ifdef FFT_SEQ_DRAIN_EN
            drain_cnt_q <= drain_cnt_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign oact  = oact_q;
    assign octrl = octrl_q;
    assign oaddr = addr_q;
    assign stage = stage_q;
    assign bank  = bank_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: directed scenarios then random start/abort/reset traffic,
// checked every cycle against an elapsed-time schedule model of the transform.
module tb_fft_stage_sequencer;

    localparam int N     = 4;
    localparam int DC    = 3;
    localparam int L     = 1 << (N - 1);
`ifdef FFT_SEQ_DRAIN_EN
    localparam int G     = DC;
`else
    localparam int G     = 0;
`endif
    localparam int TOTAL = N * L + (N - 1) * G;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         busy, done, oact, bank;
    logic [1:0]   octrl;
    logic [N-2:0] oaddr;
    logic [3:0]   stage;

    fft_stage_sequencer #(.FFT_N(N), .DRAIN_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .oact  (oact),
        .octrl (octrl),
        .oaddr (oaddr),
        .stage (stage),
        .bank  (bank)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit m_active = 1'b0;
    int m_t0     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    // Expected outputs derived from time elapsed since the accepted start.
    task automatic compare();
        int t, s, r;
        int e_busy, e_done, e_oact, e_octrl, e_addr, e_stage, e_bank;
        bit chk_sb;
        e_busy = 0; e_done = 0; e_oact = 0; e_octrl = 0; e_addr = 0;
        e_stage = 0; e_bank = 0; chk_sb = 1'b1;
        if (m_active) begin
            t = cyc - m_t0;
            if (t == TOTAL + 1) begin
                e_done = 1;
                chk_sb = 1'b0;
            end else begin
                s = (t - 1) / (L + G);
                r = (t - 1) % (L + G);
                e_busy = 1;
                if (r < L) begin
                    e_oact  = 1;
                    e_addr  = r;
                    e_stage = s;
                    e_bank  = s % 2;
                    e_octrl = (s == 0) ? 2 : ((r % 2 == 1) ? 3 : 0);
                end else begin
                    e_stage = s + 1;
                    e_bank  = (s + 1) % 2;
                end
            end
        end
        check("busy",  32'(busy),  32'(e_busy));
        check("done",  32'(done),  32'(e_done));
        check("oact",  32'(oact),  32'(e_oact));
        check("octrl", 32'(octrl), 32'(e_octrl));
        check("oaddr", 32'(oaddr), 32'(e_addr));
        if (chk_sb) begin
            check("stage", 32'(stage), 32'(e_stage));
            check("bank",  32'(bank),  32'(e_bank));
        end
    endtask

    // Drive inputs for the current cycle, advance the model across the edge, then compare.
    task automatic step(input bit r, input bit s, input bit a);
        int t;
        reset = r;
        start = s;
        abort = a;
        t = cyc - m_t0;
        if (r) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (a || t >= TOTAL + 1) m_active = 1'b0;
        end else if (s && !a) begin
            m_active = 1'b1;
            m_t0     = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    int done_seen;

    initial begin
        // reset state
        step(1, 0, 0);
        step(1, 1, 1);
        step(0, 0, 0);

        // basic transform: start at relative edge 0, done on relative cycle TOTAL+1
        step(0, 1, 0);
        done_seen = 0;
        for (int i = 1; i <= TOTAL + 4; i++) begin
            step(0, 0, 0);
            if (done === 1'b1) done_seen++;
        end
        check("done_count", 32'(done_seen), 32'd1);

        // start while busy is ignored
        step(0, 1, 0);
        for (int i = 1; i <= TOTAL + 4; i++) step(0, i == 5, 0);

        // abort mid-transform, then quiet through cycle 50
        step(0, 1, 0);
        done_seen = 0;
        for (int i = 1; i <= 50; i++) begin
            step(0, 0, i == 12);
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        // reset mid-transform, restart at cycle 25
        step(0, 1, 0);
        for (int i = 1; i <= 25 + TOTAL + 4; i++) step(i == 20, i == 25, 0);

        // start and abort together in idle: abort wins
        step(0, 1, 1);
        step(0, 0, 0);

        // start in the done cycle is ignored
        step(0, 1, 0);
        for (int i = 1; i <= TOTAL + 4; i++) step(0, i == TOTAL + 1, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 79) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 The block SHALL have parameter FFT_N, default 10, meaning log2 of the FFT point count (2..12).
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 8, meaning the idle gap between stages when draining is compiled in (1..255).
REQ-003 Port clk, input, 1 bit: clock, all logic on rising edge.
REQ-004 Port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port start, input, 1 bit: single-cycle request to begin a full transform.
REQ-006 Port abort, input, 1 bit: cancel the transform in progress.
REQ-007 Port busy, output, 1 bit: high from the accepted start until done or abort.
REQ-008 Port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-009 Port oact, output, 1 bit: butterfly-issue valid, drives the bridge iact.
REQ-010 Port octrl, output, 2 bits: operand mux control, drives the bridge ictrl.
REQ-011 Port oaddr, output, FFT_N-1 bits: butterfly memory address, drives the bridge address input.
REQ-012 Port stage, output, 4 bits: current stage index, 0..FFT_N-1.
REQ-013 Port bank, output, 1 bit: ping-pong read bank select.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN and FIN, with all outputs registered.
REQ-015 In IDLE, start=1 SHALL move the FSM to RUN: stage=0, oaddr=0, bank=0, busy=1 on the next cycle.
REQ-016 In RUN, oact SHALL be 1 every cycle, and oaddr SHALL increment by 1 each cycle from 0 to 2^(FFT_N-1)-1.
REQ-017 In stage 0, octrl SHALL be 2'b10 on every cycle.
REQ-018 In stages 1..FFT_N-1, octrl SHALL be 2'b00 when oaddr[0]=0 and 2'b11 when oaddr[0]=1.
REQ-019 When oaddr reaches its maximum in a stage below FFT_N-1, on the next cycle oaddr SHALL wrap to 0, stage SHALL increment and bank SHALL toggle.
REQ-020 When oaddr reaches its maximum in the stage equal to FFT_N-1, the FSM SHALL enter FIN on the next cycle with oact=0.
REQ-021 In FIN, the block SHALL hold for one cycle with done=1 and busy=0, then return to IDLE.
REQ-022 Outside RUN, oact SHALL be 0, octrl 2'b00 and oaddr 0.
REQ-023 A start received while busy=1 or in FIN SHALL be ignored.
REQ-024 In any non-IDLE state, abort=1 SHALL return the FSM to IDLE on the next cycle: oact=0, busy=0, no done pulse, stage=0, bank=0.
REQ-025 If start and abort are both high in IDLE, abort SHALL win and the block SHALL stay IDLE.
REQ-026 The stage counter SHALL never exceed FFT_N-1.
REQ-027 The address counter SHALL wrap modulo 2^(FFT_N-1).

Reset
REQ-028 With reset=1, on the next edge the FSM SHALL be IDLE and busy, done, oact, octrl, oaddr, stage and bank SHALL all be 0.
REQ-029 Reset SHALL take priority over start and abort.
REQ-030 Reset mid-transform SHALL produce no done pulse.

Configuration
REQ-031 With macro FFT_SEQ_DRAIN_EN defined, each stage-to-stage transition SHALL pass through DRAIN for exactly DRAIN_CYCLES cycles with oact=0 before RUN resumes, with stage and bank already updated.
REQ-032 With FFT_SEQ_DRAIN_EN defined, there SHALL be no DRAIN after the last stage.
REQ-033 Without FFT_SEQ_DRAIN_EN, the DRAIN state SHALL not exist and stages SHALL run back-to-back with no oact gap.

Verification (FFT_N=4, start sampled at edge 0)
REQ-034 Basic transform, no macro: start pulse -> oact high on cycles 1..32; stage 0 octrl=10; stages 1..3 octrl alternates 00,11; done on cycle 33 only; busy high on cycles 1..32.
REQ-035 Draining, FFT_SEQ_DRAIN_EN with DRAIN_CYCLES=3 -> oact low on cycles 9-11, 20-22 and 31-33; done on cycle 42.
REQ-036 Address wrap and bank toggle -> oaddr sequence 0..7,0..7,...; bank = 0,1,0,1 across stages 0..3.
REQ-037 Abort at cycle 12 -> cycle 13: IDLE, oact=0, busy=0; no done through cycle 50.
REQ-038 Start at cycle 5 while busy -> ignored, done still on cycle 33.
REQ-039 Reset at cycle 20 -> cycle 21: all outputs 0; a new start at cycle 25 -> done on cycle 58.
